// File: rtl/test_port_uart.sv
// Serial test-register responder: 8N1 select command in, selects TRS, returns 32-bit TR as four 8N1 bytes.
// Latency: TRS/BUSY one cycle after the command stop sample, TR captured two cycles later, start bit one cycle after capture.
// Backpressure: none; commands arriving while BUSY is high are dropped, non-command bytes are ignored.
module test_port_uart #(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned WIDTH   = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RXD,
    output logic             TXD,
    output logic [3:0]       TRS,
    input  logic [WIDTH-1:0] TR,
    output logic             BUSY
);

    localparam int NBYTES  = WIDTH / 8;
    localparam int FRAME_W = NBYTES * 10;
    localparam int BCNT_W  = $clog2(FRAME_W);

    localparam logic [15:0]       DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0]       HALF_LAST = 16'(CLK_DIV / 2 - 1);
    localparam logic [BCNT_W-1:0] TX_LAST   = BCNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {C_IDLE, C_SELECT, C_CAPTURE, C_SEND} ctl_state_t;

    // ---------------- input synchronizer ----------------
    logic rx_s1_q, rx_s2_q, rx_prev_q;

    // Two-flop synchronizer plus a history flop for falling-edge detection; idle-high after reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= RXD;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // ---------------- receiver ----------------
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_vld_q, rx_vld_d;
    logic [7:0]  rx_dat_q, rx_dat_d;

    // Receiver state and byte registers; rx_vld_q is a one-cycle pulse per good frame.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_state_q <= RX_IDLE;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_vld_q   <= 1'b0;
            rx_dat_q   <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_vld_q   <= rx_vld_d;
            rx_dat_q   <= rx_dat_d;
        end
    end

    // Receiver next state: half-bit wait to the start centre, then one sample per bit period.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_vld_d   = 1'b0;
        rx_dat_d   = rx_dat_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_div_d   = HALF_LAST;
                end
            end
            RX_START: begin
                if (rx_div_q == 16'd0) begin
                    if (rx_s2_q) begin
                        // Line is high again at the start centre: a glitch, not a frame.
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_div_d   = DIV_LAST;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_div_d = rx_div_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_div_q == 16'd0) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_div_d = DIV_LAST;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_div_d = rx_div_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_div_q == 16'd0) begin
                    rx_state_d = RX_IDLE;
                    // A low stop bit is a framing error: the byte is silently dropped.
                    if (rx_s2_q) begin
                        rx_vld_d = 1'b1;
                        rx_dat_d = rx_sh_q;
                    end
                end else begin
                    rx_div_d = rx_div_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- control / transmitter ----------------
    ctl_state_t          ctl_state_q, ctl_state_d;
    logic [3:0]          trs_q, trs_d;
    logic                busy_q, busy_d;
    logic                txd_q, txd_d;
    logic [15:0]         tx_div_q, tx_div_d;
    logic [BCNT_W-1:0]   tx_bit_q, tx_bit_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [FRAME_W-1:0]  frame_load;

    // Wrap each TR byte (low byte first) in start/stop bits so the whole response shifts out LSB first.
    always_comb begin
        frame_load = '1;
        for (int b = 0; b < NBYTES; b++) begin
            frame_load[b*10 +: 10] = {1'b1, TR[b*8 +: 8], 1'b0};
        end
    end

    // Control and transmit registers; TXD idles high and is forced high by reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ctl_state_q <= C_IDLE;
            trs_q       <= 4'h0;
            busy_q      <= 1'b0;
            txd_q       <= 1'b1;
            tx_div_q    <= '0;
            tx_bit_q    <= '0;
            frame_q     <= '1;
        end else begin
            ctl_state_q <= ctl_state_d;
            trs_q       <= trs_d;
            busy_q      <= busy_d;
            txd_q       <= txd_d;
            tx_div_q    <= tx_div_d;
            tx_bit_q    <= tx_bit_d;
            frame_q     <= frame_d;
        end
    end

    // Control next state: accept command, let TR settle two cycles, capture, then stream 40 bits.
    always_comb begin
        ctl_state_d = ctl_state_q;
        trs_d       = trs_q;
        busy_d      = busy_q;
        txd_d       = txd_q;
        tx_div_d    = tx_div_q;
        tx_bit_d    = tx_bit_q;
        frame_d     = frame_q;
        case (ctl_state_q)
            C_IDLE: begin
                txd_d = 1'b1;
                if (rx_vld_q && (rx_dat_q[7:4] == 4'hA)) begin
                    ctl_state_d = C_SELECT;
                    trs_d       = rx_dat_q[3:0];
                    busy_d      = 1'b1;
                    tx_div_d    = 16'd1;
                end
            end
            C_SELECT: begin
                if (tx_div_q == 16'd0) begin
                    frame_d     = frame_load;
                    ctl_state_d = C_CAPTURE;
                end else begin
                    tx_div_d = tx_div_q - 16'd1;
                end
            end
            C_CAPTURE: begin
                txd_d       = frame_q[0];
                frame_d     = {1'b1, frame_q[FRAME_W-1:1]};
                tx_bit_d    = TX_LAST;
                tx_div_d    = DIV_LAST;
                ctl_state_d = C_SEND;
            end
            C_SEND: begin
                if (tx_div_q == 16'd0) begin
                    if (tx_bit_q == '0) begin
                        // Last stop bit has run its full period.
                        ctl_state_d = C_IDLE;
                        busy_d      = 1'b0;
                        txd_d       = 1'b1;
                    end else begin
                        txd_d    = frame_q[0];
                        frame_d  = {1'b1, frame_q[FRAME_W-1:1]};
                        tx_bit_d = tx_bit_q - BCNT_W'(1);
                        tx_div_d = DIV_LAST;
                    end
                end else begin
                    tx_div_d = tx_div_q - 16'd1;
                end
            end
            default: ctl_state_d = C_IDLE;
        endcase
    end

    assign TXD  = txd_q;
    assign TRS  = trs_q;
    assign BUSY = busy_q;

endmodule

// File: doc/test_port_uart.md
# test_port_uart

Serial responder for the computer's test-register port. It receives a one-byte select command on an 8N1 serial line and drives the selected test-select code onto `TRS`. It then captures the 32-bit test output `TR` and transmits it back as four 8N1 bytes. It sits beside `comp`, so a host or bench can read any test register over two wires instead of driving `TRS` and probing `TR` directly.

## Interface
Parameters:
- `CLK_DIV`, 16: clock cycles per serial bit. Legal range 4..65535; must be even.
- `WIDTH`, 32: width of `TR`. Fixed at 32 in this version; four response bytes.

Ports:
- `CLK`  input  1  system clock; all state on the rising edge.
- `RESET`  input  1  asynchronous, active-low reset.
- `RXD`  input  1  serial command input; asynchronous to `CLK`; idle high.
- `TXD`  output  1  serial response output; idle high.
- `TRS`  output  4  test-select code driven to the computer.
- `TR`  input  32  test output from the computer; must reflect `TRS` within 2 cycles.
- `BUSY`  output  1  high from command acceptance until the last response stop bit ends.

## Operation
- `RXD` passes through a 2-flop synchronizer; the receiver uses only the synchronized value.
- Receiver states:
  - IDLE → START on a synchronized 1→0 transition.
  - START: wait `CLK_DIV/2` cycles, then sample. If the sample is 1, treat it as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: 8 samples, one every `CLK_DIV` cycles, LSB first.
  - STOP: one sample `CLK_DIV` cycles after the last data bit. Stop = 0 is a framing error; discard the byte and return to IDLE.
- The receiver runs continuously, including while `BUSY` is high.
- A received byte is a command only if bits[7:4] = 4'hA. The byte is accepted only if `BUSY` = 0.
  - Non-command bytes are ignored with no state change.
  - Commands arriving while `BUSY` = 1 are dropped with no effect.
- Control states:
  - IDLE → SELECT on acceptance: `TRS` ← byte[3:0]; `BUSY` ← 1.
  - SELECT: two wait cycles.
  - CAPTURE: shift register ← `TR`.
  - SEND: four bytes, `TR`[7:0] first, then [15:8], [23:16], [31:24].
  - Each byte is start (0), 8 data bits LSB first, stop (1). Every bit lasts exactly `CLK_DIV` cycles. Bytes go back-to-back with no idle gap.
  - After the fourth stop bit, return to IDLE and clear `BUSY`.
- `TRS` holds its last value until the next accepted command; it is not cleared at the end of a transfer.
- Changes on `TR` after CAPTURE do not affect the response.

## Timing
- Reset values: `TXD` = 1, `TRS` = 4'h0, `BUSY` = 0; receiver and control FSMs in IDLE; synchronizer flops = 1.
- `RESET` asserted mid-reception or mid-transmission aborts immediately. `TXD` returns to 1 asynchronously; no partial frame resumes after release.
- Let E = the edge on which the stop bit is sampled valid:
  - `TRS` and `BUSY` update at E+1.
  - `TR` is captured at E+3.
  - `TXD` drops for the start bit at E+4.
  - `BUSY` falls at E+4+40·`CLK_DIV`, coincident with the end of the fourth stop bit.
- Input latency: the `RXD` start edge to receiver START is 2 cycles (synchronizer). Sample points are therefore offset 2 cycles later than the ideal bit centres.
- A command whose stop sample falls on the same edge that `BUSY` clears is accepted, because `BUSY` is evaluated after clearing.
- Bit counters wrap only within a frame; `CLK_DIV` counts from `CLK_DIV`−1 down to 0.

## Test plan
All scenarios use `CLK_DIV` = 4.
- Reset, then idle 50 cycles → `TXD` = 1, `TRS` = 0, `BUSY` = 0 throughout.
- Send 0xA2 with `TR` = 32'h12345678 → `TRS` = 2 one cycle after stop sample. `TXD` carries 0x78, 0x56, 0x34, 0x12 (8N1, 4 cycles/bit). `BUSY` is high for exactly 163 cycles (E+1 through E+163), deasserting at E+164.
- Send 0x37, then 0xA5 → 0x37 ignored (no `BUSY`, `TRS` unchanged). 0xA5 sets `TRS` = 5 and returns 4 bytes.
- Send 0xA1 with stop bit forced 0 → no `TRS` change, no `BUSY`, `TXD` stays 1. A 1-cycle low glitch on `RXD` also produces no reception.
- Send 0xA3, then 0xA4 during the response → `TRS` stays 3, only 4 bytes sent. 0xA4 sent after `BUSY` falls → `TRS` = 4 and a new response.
- Assert `RESET` during the 2nd response byte → `TXD` = 1 and `BUSY` = 0 immediately; after release, no further bytes until a new command.
